paddle_motion: RTL

//  Frame-rate paddle position controller for the breakout display pipeline.

---
 rtl/paddle_pkg.sv | 24 ++
 rtl/paddle_speed_ramp.sv | 45 ++++
 rtl/paddle_motion.sv | 101 ++++++++++
 3 files changed

// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared paddle state type, default geometry and clamp helper
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } paddle_state_e;

  localparam int DEF_XW        = 10;
  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_HALF_W    = 40;
  localparam int DEF_MIN_SPEED = 1;
  localparam int DEF_MAX_SPEED = 8;
  localparam int DEF_ACCEL     = 1;

  // Signed so callers can pass a position that has stepped past either edge.
  function automatic int clamp_pos(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/paddle_speed_ramp.sv
// rtl/paddle_speed_ramp.sv - per-tick paddle speed ramp with clamp and idle reset
module paddle_speed_ramp
  import paddle_pkg::*;
#(
  parameter int MIN_SPEED = DEF_MIN_SPEED,
  parameter int MAX_SPEED = DEF_MAX_SPEED,
  parameter int ACCEL     = DEF_ACCEL,
  parameter int SW        = $clog2(MAX_SPEED + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          tick,
  input  logic          dir,
  input  logic          same_dir,
  input  logic          clamp,
  output logic [SW-1:0] speed_n
);

  logic [SW-1:0] speed_q;
  int            sum;

  always_comb begin
    sum     = int'(speed_q) + ACCEL;
    speed_n = SW'(MIN_SPEED);
    if (same_dir) begin
      speed_n = (sum > MAX_SPEED) ? SW'(MAX_SPEED) : SW'(sum);
    end
  end

  // A clamped step restarts the ramp so pushing into a wall never builds speed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      speed_q <= '0;
    end else if (tick) begin
      if (!dir) begin
        speed_q <= '0;
      end else if (clamp) begin
        speed_q <= SW'(MIN_SPEED);
      end else begin
        speed_q <= speed_n;
      end
    end
  end

endmodule

// File: rtl/paddle_motion.sv
// rtl/paddle_motion.sv - frame-rate paddle position, direction FSM and edge clamping
module paddle_motion
  import paddle_pkg::*;
#(
  parameter int XW        = DEF_XW,
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int HALF_W    = DEF_HALF_W,
  parameter int MIN_SPEED = DEF_MIN_SPEED,
  parameter int MAX_SPEED = DEF_MAX_SPEED,
  parameter int ACCEL     = DEF_ACCEL
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          frame_tick,
  input  logic          left,
  input  logic          right,
  input  logic          serve,
  output logic [XW-1:0] x_out,
  output logic          moving,
  output logic          at_left,
  output logic          at_right
);

  localparam int XMIN   = HALF_W;
  localparam int XMAX   = SCREEN_W - 1 - HALF_W;
  localparam int CENTRE = SCREEN_W / 2;
  localparam int SW     = $clog2(MAX_SPEED + 1);

  if (XMIN >= XMAX) begin : g_bad_width
    $error("paddle_motion: HALF_W too large for SCREEN_W");
  end
  if (SCREEN_W > (2 ** XW)) begin : g_bad_xw
    $error("paddle_motion: SCREEN_W does not fit in XW bits");
  end
  if (MIN_SPEED <= 0 || MAX_SPEED < MIN_SPEED) begin : g_bad_speed
    $error("paddle_motion: need MAX_SPEED >= MIN_SPEED > 0");
  end

  paddle_state_e state_q;
  logic [XW-1:0] x_q;
  logic          moving_q;

  logic          l_only, r_only, step, same_dir, clamp;
  logic [SW-1:0] speed_n;
  logic [XW-1:0] x_lim;
  int            x_n;

  assign l_only   = left & ~right;
  assign r_only   = right & ~left;
  assign step     = ~serve & (l_only | r_only);
  assign same_dir = ((state_q == MOVE_L) && l_only) || ((state_q == MOVE_R) && r_only);

  // Signed integer arithmetic so a step past either edge is seen, never wrapped.
  always_comb begin
    x_n   = r_only ? (int'(x_q) + int'(speed_n)) : (int'(x_q) - int'(speed_n));
    clamp = (x_n < XMIN) || (x_n > XMAX);
    x_lim = XW'(clamp_pos(x_n, XMIN, XMAX));
  end

  paddle_speed_ramp #(
    .MIN_SPEED(MIN_SPEED),
    .MAX_SPEED(MAX_SPEED),
    .ACCEL    (ACCEL),
    .SW       (SW)
  ) u_ramp (
    .clk     (clk),
    .resetn  (resetn),
    .tick    (frame_tick),
    .dir     (step),
    .same_dir(same_dir),
    .clamp   (clamp),
    .speed_n (speed_n)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q      <= XW'(CENTRE);
      state_q  <= IDLE;
      moving_q <= 1'b0;
    end else if (frame_tick) begin
      if (serve) begin
        x_q      <= XW'(CENTRE);
        state_q  <= IDLE;
        moving_q <= 1'b0;
      end else if (!step) begin
        state_q  <= IDLE;
        moving_q <= 1'b0;
      end else begin
        x_q      <= x_lim;
        state_q  <= r_only ? MOVE_R : MOVE_L;
        moving_q <= 1'b1;
      end
    end
  end

  assign x_out    = x_q;
  assign moving   = moving_q;
  assign at_left  = (x_q == XW'(XMIN));
  assign at_right = (x_q == XW'(XMAX));

endmodule
